// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/valid read port
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, imem handshake, next-PC select
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr,
    output logic [5:0]                 opcode,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    input  logic                       jump,
    input  logic                       branch,
    input  logic                       alu_zero,
    input  logic                       advance,
    output logic                       fetch_err,
    output logic [31:0]                retired
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetchState;

    // Retry fires when the counter would step onto TIMEOUT-1, so WAIT lasts at most TIMEOUT-1 cycles.
    localparam logic [7:0] WaitLimit = 8'(TIMEOUT - 2);

    fetchState   state;
    logic [7:0]  waitCnt;
    logic [31:0] nextPc;
    logic [31:0] branchOff;

    assign pc_plus4 = pc + 32'd4;
    assign opcode   = instr[31:26];

    always_comb begin
        branchOff = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (jump) begin
            nextPc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            nextPc = pc_plus4 + branchOff;
        end else begin
            nextPc = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            instr          <= '0;
            instr_valid    <= 1'b0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            fetch_err      <= 1'b0;
            retired        <= '0;
            waitCnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem.imem_req  <= 1'b1;
                    imem.imem_addr <= pc;
                end
                REQ: begin
                    state         <= WAIT;
                    imem.imem_req <= 1'b0;
                    waitCnt       <= '0;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (waitCnt == WaitLimit) begin
                        fetch_err      <= 1'b1;
                        waitCnt        <= '0;
                        state          <= REQ;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc             <= nextPc;
                        retired        <= retired + 32'd1;
                        instr_valid    <= 1'b0;
                        state          <= REQ;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= nextPc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] MAIN_PC = 32'h0040_0000;
    localparam logic [31:0] HI_PC   = 32'h1000_000C;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
    localparam int          TMO     = 4;

    logic        clk;
    logic        rst_n;
    logic        rvalid;
    logic [31:0] rdata;
    logic        jump, branch, alu_zero, advance;

    int errors = 0;
    int checks = 0;

    logic [31:0] expPc, expRetired, expInstr;
    logic        expErr;

    instr_fetch_unit_if ifm();
    instr_fetch_unit_if ifh();
    instr_fetch_unit_if ifw();
    assign ifm.imem_rvalid = rvalid;
    assign ifm.imem_rdata  = rdata;
    assign ifh.imem_rvalid = rvalid;
    assign ifh.imem_rdata  = rdata;
    assign ifw.imem_rvalid = rvalid;
    assign ifw.imem_rdata  = rdata;

    logic [31:0] m_instr, m_pc, m_pc4, m_ret;
    logic [5:0]  m_op;
    logic        m_iv, m_err;
    logic [31:0] h_instr, h_pc, h_pc4, h_ret;
    logic [5:0]  h_op;
    logic        h_iv, h_err;
    logic [31:0] w_instr, w_pc, w_pc4, w_ret;
    logic [5:0]  w_op;
    logic        w_iv, w_err;

    instr_fetch_unit #(.RESET_PC(MAIN_PC), .TIMEOUT(TMO)) u_main (
        .clk(clk), .rst_n(rst_n), .imem(ifm), .instr(m_instr), .opcode(m_op),
        .instr_valid(m_iv), .pc(m_pc), .pc_plus4(m_pc4), .jump(jump), .branch(branch),
        .alu_zero(alu_zero), .advance(advance), .fetch_err(m_err), .retired(m_ret));

    instr_fetch_unit #(.RESET_PC(HI_PC), .TIMEOUT(TMO)) u_hi (
        .clk(clk), .rst_n(rst_n), .imem(ifh), .instr(h_instr), .opcode(h_op),
        .instr_valid(h_iv), .pc(h_pc), .pc_plus4(h_pc4), .jump(jump), .branch(branch),
        .alu_zero(alu_zero), .advance(advance), .fetch_err(h_err), .retired(h_ret));

    instr_fetch_unit #(.RESET_PC(WRAP_PC), .TIMEOUT(TMO)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem(ifw), .instr(w_instr), .opcode(w_op),
        .instr_valid(w_iv), .pc(w_pc), .pc_plus4(w_pc4), .jump(jump), .branch(branch),
        .alu_zero(alu_zero), .advance(advance), .fetch_err(w_err), .retired(w_ret));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-PC from the instruction-set rules, using plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = int'($signed(ins[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_instr(input logic [31:0] word, input int delay, input bit staleReq, input bit strayAdv);
        for (int k = 0; k < 20 && !ifm.imem_req; k++) step();
        checks++;
        if (ifm.imem_req !== 1'b1) begin errors++; $display("FAIL req_wait: imem_req=%b want 1", ifm.imem_req); end
        checks++;
        if (ifm.imem_addr !== expPc) begin errors++; $display("FAIL req_addr: got %h want %h", ifm.imem_addr, expPc); end
        rvalid = staleReq;
        rdata = ~word;
        advance = strayAdv;
        step();
        rvalid = 1'b0;
        for (int k = 1; k < delay; k++) step();
        rvalid = 1'b1;
        rdata = word;
        step();
        rvalid = 1'b0;
        advance = 1'b0;
        expInstr = word;
        checks++;
        if (m_iv !== 1'b1) begin errors++; $display("FAIL instr_valid: got %b want 1", m_iv); end
        checks++;
        if (m_instr !== word || m_op !== word[31:26]) begin
            errors++; $display("FAIL instr_capture: got %h/%h want %h/%h", m_instr, m_op, word, word[31:26]);
        end
        checks++;
        if (m_pc4 !== expPc + 32'd4) begin errors++; $display("FAIL pc_plus4: got %h want %h", m_pc4, expPc + 32'd4); end
    endtask

    task automatic do_advance(input logic j, input logic b, input logic z, input int holdCycles);
        for (int k = 0; k < holdCycles; k++) begin
            rvalid = 1'($urandom_range(0, 1));
            rdata = $urandom;
            step();
            checks++;
            if (m_iv !== 1'b1 || m_instr !== expInstr || m_pc !== expPc) begin
                errors++; $display("FAIL hold_stable: iv=%b instr=%h pc=%h want 1 %h %h", m_iv, m_instr, m_pc, expInstr, expPc);
            end
        end
        rvalid = 1'b0;
        jump = j; branch = b; alu_zero = z; advance = 1'b1;
        step();
        advance = 1'b0;
        jump = $urandom_range(0, 1); branch = $urandom_range(0, 1); alu_zero = $urandom_range(0, 1);
        expPc = model_next(expPc, expInstr, j, b, z);
        expRetired = expRetired + 32'd1;
        checks++;
        if (m_pc !== expPc || ifm.imem_addr !== expPc || ifm.imem_req !== 1'b1) begin
            errors++; $display("FAIL next_pc: pc=%h addr=%h req=%b want %h %h 1", m_pc, ifm.imem_addr, ifm.imem_req, expPc, expPc);
        end
        checks++;
        if (m_ret !== expRetired || m_iv !== 1'b0 || m_err !== expErr) begin
            errors++; $display("FAIL advance_state: ret=%0d iv=%b err=%b want %0d 0 %b", m_ret, m_iv, m_err, expRetired, expErr);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rvalid = 1'b0; rdata = '0;
        jump = 1'b0; branch = 1'b0; alu_zero = 1'b0; advance = 1'b0;
        step(); step();
        checks++;
        if (ifm.imem_req !== 1'b0 || ifm.imem_addr !== MAIN_PC || m_pc !== MAIN_PC) begin
            errors++; $display("FAIL reset_pc: req=%b addr=%h pc=%h want 0 %h", ifm.imem_req, ifm.imem_addr, m_pc, MAIN_PC);
        end
        checks++;
        if (m_instr !== 32'h0 || m_op !== 6'h0 || m_iv !== 1'b0 || m_err !== 1'b0 || m_ret !== 32'h0) begin
            errors++; $display("FAIL reset_regs: instr=%h op=%h iv=%b err=%b ret=%h want zeros", m_instr, m_op, m_iv, m_err, m_ret);
        end
        checks++;
        if (w_pc !== WRAP_PC || w_pc4 !== 32'h0 || h_pc !== HI_PC) begin
            errors++; $display("FAIL reset_params: wpc=%h wpc4=%h hpc=%h want %h 0 %h", w_pc, w_pc4, h_pc, WRAP_PC, HI_PC);
        end
        expPc = MAIN_PC; expRetired = '0; expErr = 1'b0; expInstr = '0;
        rst_n = 1'b1;
        step();
        checks++;
        if (ifm.imem_req !== 1'b1 || ifm.imem_addr !== MAIN_PC) begin
            errors++; $display("FAIL first_req: req=%b addr=%h want 1 %h", ifm.imem_req, ifm.imem_addr, MAIN_PC);
        end
        step();
        rvalid = 1'b1; rdata = 32'h2008_0005;
        step();
        rvalid = 1'b0;
        expInstr = 32'h2008_0005;
        checks++;
        if (m_iv !== 1'b1 || m_op !== 6'b001000 || m_pc4 !== 32'h0040_0004) begin
            errors++; $display("FAIL first_instr: iv=%b op=%b pc4=%h want 1 001000 00400004", m_iv, m_op, m_pc4);
        end
    endtask

    task automatic test_jump_priority;
        do_advance(1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (m_pc !== 32'h0040_0004 || m_ret !== 32'd1 || w_pc !== 32'h0 || w_pc4 !== 32'h4 || h_pc !== 32'h1000_0010) begin
            errors++; $display("FAIL seq_first: pc=%h ret=%0d wpc=%h wpc4=%h hpc=%h want 00400004 1 0 4 10000010", m_pc, m_ret, w_pc, w_pc4, h_pc);
        end
        fetch_instr(32'h0800_0040, 1, 1'b0, 1'b0);
        do_advance(1'b1, 1'b1, 1'b1, 0);
        checks++;
        if (m_pc !== 32'h0000_0100 || h_pc !== 32'h1000_0100) begin
            errors++; $display("FAIL jump_priority: pc=%h hpc=%h want 00000100 10000100", m_pc, h_pc);
        end
    endtask

    task automatic test_sequential;
        fetch_instr(32'h0000_0020, 2, 1'b1, 1'b1);
        do_advance(1'b0, 1'b0, 1'b0, 2);
        checks++;
        if (ifm.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL seq_addr: got %h want 00000104", ifm.imem_addr); end
    endtask

    task automatic test_branch;
        fetch_instr(32'h0800_0080, 1, 1'b0, 1'b0);
        do_advance(1'b1, 1'b0, 1'b0, 0);
        fetch_instr(32'h1000_FFFE, 1, 1'b0, 1'b0);
        do_advance(1'b0, 1'b1, 1'b1, 1);
        checks++;
        if (m_pc !== 32'h0000_01FC) begin errors++; $display("FAIL branch_taken: got %h want 000001FC", m_pc); end
        fetch_instr(32'h0000_0000, 3, 1'b0, 1'b0);
        do_advance(1'b0, 1'b0, 1'b1, 0);
        fetch_instr(32'h1000_FFFE, 2, 1'b0, 1'b0);
        do_advance(1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (m_pc !== 32'h0000_0204) begin errors++; $display("FAIL branch_not_taken: got %h want 00000204", m_pc); end
    endtask

    task automatic test_timeout;
        logic [31:0] prev;
        prev = m_instr;
        step();
        rvalid = 1'b0;
        for (int k = 0; k < 12 && !ifm.imem_req; k++) step();
        expErr = 1'b1;
        checks++;
        if (ifm.imem_req !== 1'b1 || ifm.imem_addr !== expPc || m_err !== 1'b1) begin
            errors++; $display("FAIL retry: req=%b addr=%h err=%b want 1 %h 1", ifm.imem_req, ifm.imem_addr, m_err, expPc);
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        checks++;
        if (m_iv !== 1'b0 || m_instr !== prev) begin
            errors++; $display("FAIL stale_in_req: iv=%b instr=%h want 0 %h", m_iv, m_instr, prev);
        end
        step(); step();
        rvalid = 1'b1; rdata = 32'h2409_0007;
        step();
        rvalid = 1'b0;
        expInstr = 32'h2409_0007;
        checks++;
        if (m_iv !== 1'b1 || m_instr !== 32'h2409_0007 || m_err !== 1'b1) begin
            errors++; $display("FAIL retry_capture: iv=%b instr=%h err=%b want 1 24090007 1", m_iv, m_instr, m_err);
        end
        do_advance(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_reset_mid;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        step();
        rvalid = 1'b0;
        expPc = MAIN_PC; expRetired = '0; expErr = 1'b0;
        checks++;
        if (m_instr !== 32'h0 || m_iv !== 1'b0 || m_pc !== MAIN_PC || m_ret !== 32'h0 || m_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset: instr=%h iv=%b pc=%h ret=%h err=%b want 0 0 %h 0 0", m_instr, m_iv, m_pc, m_ret, m_err, MAIN_PC);
        end
        checks++;
        if (ifm.imem_req !== 1'b1 || ifm.imem_addr !== MAIN_PC) begin
            errors++; $display("FAIL mid_reset_req: req=%b addr=%h want 1 %h", ifm.imem_req, ifm.imem_addr, MAIN_PC);
        end
    endtask

    task automatic test_random;
        logic [31:0] w;
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            fetch_instr(w, $urandom_range(1, TMO - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_advance(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_jump_priority();
        test_sequential();
        test_branch();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
